// File: rtl/shift_pkg.sv
// Shared constants, opcodes and state encoding for the shift execute unit.
// SHIFT_ROTATE_EN adds the ROTR/ROTL opcodes to the iterating set.
package shift_pkg;

    localparam int WIDTH = 20;
    localparam int AMT_W = 5;

    localparam logic [2:0] OP_SHFTR = 3'd0;
    localparam logic [2:0] OP_SHFTL = 3'd1;
    localparam logic [2:0] OP_SWAP  = 3'd2;
    localparam logic [2:0] OP_ROTR  = 3'd3;
    localparam logic [2:0] OP_ROTL  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True for opcodes that walk one bit position per SHIFT cycle.
    function automatic logic is_iter_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_SHFTR, OP_SHFTL: r = 1'b1;
`ifdef SHIFT_ROTATE_EN
            OP_ROTR, OP_ROTL:   r = 1'b1;
`endif
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    // Shifts saturate at WIDTH steps; rotates wrap modulo WIDTH (amount < 2*WIDTH).
    function automatic logic [AMT_W-1:0] step_count(input logic [2:0] op,
                                                    input logic [AMT_W-1:0] amount);
        logic [AMT_W-1:0] c;
        if (amount >= AMT_W'(WIDTH)) begin
            if (op == OP_ROTR || op == OP_ROTL) begin
                c = amount - AMT_W'(WIDTH);
            end else begin
                c = AMT_W'(WIDTH);
            end
        end else begin
            c = amount;
        end
        return c;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-position shift/rotate of the working register.
// Rotate directions exist only when SHIFT_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] value_o
);

    // Single-bit step selected by the captured opcode.
    always_comb begin
        value_o = value;
        case (op)
            OP_SHFTR: value_o = {1'b0, value[WIDTH-1:1]};
            OP_SHFTL: value_o = {value[WIDTH-2:0], 1'b0};
`ifdef SHIFT_ROTATE_EN
            OP_ROTR:  value_o = {value[0], value[WIDTH-1:1]};
            OP_ROTL:  value_o = {value[WIDTH-2:0], value[WIDTH-1]};
`endif
            default:  value_o = value;
        endcase
    end

endmodule

// File: rtl/shift_exec_unit.sv
// Sequential SHFTR/SHFTL/SWAP execute stage, one bit position per clock.
// Define SHIFT_ROTATE_EN to enable ROTR (op 3) and ROTL (op 4).
module shift_exec_unit
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [AMT_W-1:0] amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result1_q, result1_d;
    logic [WIDTH-1:0] result2_q, result2_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic             accept_s;
    logic [AMT_W-1:0] init_count_s;
    logic [WIDTH-1:0] step_out_s;

    assign accept_s     = in_valid && (state_q == ST_IDLE);
    assign init_count_s = step_count(op, amount);

    shift_step u_step (
        .value   (work_q),
        .op      (op_q),
        .value_o (step_out_s)
    );

    // State and datapath registers; reset abandons any captured operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            work_q      <= '0;
            count_q     <= '0;
            result1_q   <= '0;
            result2_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            count_q     <= count_d;
            result1_q   <= result1_d;
            result2_q   <= result2_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_iter_op(op) && (init_count_s != '0)) begin
                    state_d = ST_SHIFT;
                end else if (accept_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count_q <= AMT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs, derived from the next state.
    always_comb begin
        op_d        = op_q;
        work_d      = work_q;
        count_d     = count_q;
        result1_d   = result1_q;
        result2_d   = result2_q;
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d    = op;
                    work_d  = data1;
                    count_d = init_count_s;
                    if (op == OP_SWAP) begin
                        result1_d = data2;
                        result2_d = data1;
                    end else if (is_iter_op(op)) begin
                        if (init_count_s == '0) begin
                            result1_d = data1;
                            result2_d = '0;
                        end else begin
                            result1_d = result1_q;
                            result2_d = result2_q;
                        end
                    end else begin
                        result1_d = data1;
                        result2_d = data2;
                    end
                end else begin
                    op_d = op_q;
                end
            end
            ST_SHIFT: begin
                work_d  = step_out_s;
                count_d = count_q - AMT_W'(1);
                if (count_q <= AMT_W'(1)) begin
                    result1_d = step_out_s;
                    result2_d = '0;
                end else begin
                    result1_d = result1_q;
                end
            end
            ST_DONE: begin
                result1_d = result1_q;
            end
            default: begin
                result1_d = result1_q;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result1   = result1_q;
    assign result2   = result2_q;

endmodule
